// File: rtl/gbp_pkg.sv
// Shared defaults, types and saturating-counter update for the gshare predictor family.
// Optional build macro GBP_FWD_EN (used by gshare_spec_bp) forwards same-cycle training into the prediction.
`ifndef XLEN
`define XLEN 32
`endif

package gbp_pkg;

  localparam int DEF_HIST_BITS = 8;
  localparam int DEF_IDX_BITS  = 10;
  localparam int DEF_CTR_BITS  = 2;
  localparam int DEF_PC_LSB    = 2;

  typedef logic [DEF_HIST_BITS-1:0] ghr_t;
  typedef logic [DEF_IDX_BITS-1:0]  pht_idx_t;
  typedef logic [DEF_CTR_BITS-1:0]  ctr_t;

  // Saturates at both ends rather than wrapping.
  function automatic ctr_t sat_update(ctr_t c, logic taken);
    if (taken)
      return (c == '1) ? c : c + ctr_t'(1);
    else
      return (c == '0) ? c : c - ctr_t'(1);
  endfunction

endpackage

// File: rtl/gbp_if.sv
// Fetch/execute-side bus of the gshare predictor: prediction request and branch resolution.
interface gbp_if #(
  parameter int HIST_BITS = gbp_pkg::DEF_HIST_BITS,
  parameter int XLEN      = `XLEN
);

  logic                 F_valid;
  logic [XLEN-1:0]      F_PC;
  logic                 F_predict_taken;
  logic [HIST_BITS-1:0] F_ghr;
  logic                 X_valid;
  logic [XLEN-1:0]      X_PC;
  logic                 X_taken;
  logic                 X_mispredict;
  logic [HIST_BITS-1:0] X_ghr;

  modport master (
    output F_valid, F_PC, X_valid, X_PC, X_taken, X_mispredict, X_ghr,
    input  F_predict_taken, F_ghr
  );

  modport slave (
    input  F_valid, F_PC, X_valid, X_PC, X_taken, X_mispredict, X_ghr,
    output F_predict_taken, F_ghr
  );

endinterface

// File: rtl/gbp_counter_table.sv
// Pattern history table: array of saturating counters, one combinational read port,
// one synchronous write port that applies the saturating update to the addressed entry.
module gbp_counter_table
  import gbp_pkg::*;
#(
  parameter int IDX_BITS = DEF_IDX_BITS,
  parameter int CTR_BITS = DEF_CTR_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken,
  output logic [CTR_BITS-1:0] wr_next
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] ctrs [DEPTH];
  logic [CTR_BITS-1:0] wr_cur;

  assign rd_ctr = ctrs[rd_idx];
  assign wr_cur = ctrs[wr_idx];

  // The shared package helper is fixed to the default width; other widths use the same rule inline.
  generate
    if (CTR_BITS == DEF_CTR_BITS) begin : g_pkg_sat
      assign wr_next = sat_update(wr_cur, wr_taken);
    end else begin : g_param_sat
      always_comb begin
        wr_next = wr_cur;
        if (wr_taken && (wr_cur != '1))
          wr_next = wr_cur + CTR_BITS'(1);
        else if (!wr_taken && (wr_cur != '0))
          wr_next = wr_cur - CTR_BITS'(1);
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        ctrs[i] <= WEAK_NT;
    end else if (wr_en) begin
      ctrs[wr_idx] <= wr_next;
    end
  end

endmodule

// File: rtl/gshare_spec_bp.sv
// Gshare predictor top: index hashing, speculative global history with mispredict recovery.
// Define GBP_FWD_EN to let a same-index training write feed the same-cycle prediction.
module gshare_spec_bp
  import gbp_pkg::*;
#(
  parameter int HIST_BITS = DEF_HIST_BITS,
  parameter int IDX_BITS  = DEF_IDX_BITS,
  parameter int CTR_BITS  = DEF_CTR_BITS,
  parameter int PC_LSB    = DEF_PC_LSB
) (
  input  logic clock,
  input  logic reset,
  gbp_if.slave bus
);

  logic [HIST_BITS-1:0] spec_ghr;
  logic [HIST_BITS-1:0] ghr_after_fetch;
  logic [HIST_BITS-1:0] ghr_after_recover;
  logic [IDX_BITS-1:0]  f_idx;
  logic [IDX_BITS-1:0]  x_idx;
  logic [CTR_BITS-1:0]  rd_ctr;
  logic [CTR_BITS-1:0]  wr_next;
  logic                 pred_bit;
  logic                 unused_pc;

  function automatic logic [IDX_BITS-1:0] hash_idx(logic [`XLEN-1:0] pc, logic [HIST_BITS-1:0] ghr);
    return pc[PC_LSB +: IDX_BITS] ^ IDX_BITS'(ghr);
  endfunction

  assign f_idx     = hash_idx(bus.F_PC, spec_ghr);
  assign x_idx     = hash_idx(bus.X_PC, bus.X_ghr);
  assign unused_pc = ^{bus.F_PC, bus.X_PC};

  gbp_counter_table #(
    .IDX_BITS(IDX_BITS),
    .CTR_BITS(CTR_BITS)
  ) u_table (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (f_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (bus.X_valid),
    .wr_idx   (x_idx),
    .wr_taken (bus.X_taken),
    .wr_next  (wr_next)
  );

`ifdef GBP_FWD_EN
  assign pred_bit = (bus.X_valid && bus.F_valid && (x_idx == f_idx)) ? wr_next[CTR_BITS-1]
                                                                       : rd_ctr[CTR_BITS-1];
`else
  assign pred_bit = rd_ctr[CTR_BITS-1];
`endif

  assign bus.F_predict_taken = !reset && bus.F_valid && pred_bit;
  assign bus.F_ghr           = reset ? '0 : spec_ghr;

  // Truncating the concatenation drops the oldest bit; with one history bit only the new bit remains.
  assign ghr_after_fetch   = HIST_BITS'({spec_ghr, bus.F_predict_taken});
  assign ghr_after_recover = HIST_BITS'({bus.X_ghr, bus.X_taken});

  // Recovery wins over a same-cycle fetch, which is squashed and must not shift history.
  always_ff @(posedge clock) begin
    if (reset)
      spec_ghr <= '0;
    else if (bus.X_valid && bus.X_mispredict)
      spec_ghr <= ghr_after_recover;
    else if (bus.F_valid)
      spec_ghr <= ghr_after_fetch;
  end

endmodule

// File: tb/tb_gshare_spec_bp.sv
// Bench for gshare_spec_bp: hand-derived vector table for the corner cases, then a
// randomised run against a reference model; expectations flow through a scoreboard queue.
module tb_gshare_spec_bp;

  localparam int HB = 8;
  localparam int IB = 10;
`ifdef GBP_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  gbp_if #(.HIST_BITS(HB), .XLEN(32)) bus ();

  gshare_spec_bp #(
    .HIST_BITS(HB),
    .IDX_BITS (IB),
    .CTR_BITS (2),
    .PC_LSB   (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fpc;
    logic        xv;
    logic [31:0] xpc;
    logic        xt;
    logic        xm;
    logic [7:0]  xghr;
    logic        exp_pred;
    logic [7:0]  exp_ghr;
  } vec_t;

  typedef struct {
    logic       pred;
    logic [7:0] ghr;
    string      tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  int         mpht [1024];
  logic [7:0] mghr;

  function automatic vec_t mk(logic rst, logic fv, logic [31:0] fpc, logic xv, logic [31:0] xpc,
                              logic xt, logic xm, logic [7:0] xghr, logic ep, logic [7:0] eg);
    vec_t v;
    v.rst = rst; v.fv = fv; v.fpc = fpc; v.xv = xv; v.xpc = xpc;
    v.xt = xt; v.xm = xm; v.xghr = xghr; v.exp_pred = ep; v.exp_ghr = eg;
    return v;
  endfunction

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got 0 entries, want 1");
      mismatched++;
      return;
    end
    e = sb.pop_front();
    compared++;
    if (bus.F_predict_taken !== e.pred) begin
      $display("[TB] FAIL %s pred: got %0b want %0b", e.tag, bus.F_predict_taken, e.pred);
      mismatched++;
    end
    compared++;
    if (bus.F_ghr !== e.ghr) begin
      $display("[TB] FAIL %s ghr: got 0x%02h want 0x%02h", e.tag, bus.F_ghr, e.ghr);
      mismatched++;
    end
  endtask

  task automatic apply_stimulus(vec_t v, string tag);
    exp_t e;
    @(negedge clock);
    reset            = v.rst;
    bus.F_valid      = v.fv;
    bus.F_PC         = v.fpc;
    bus.X_valid      = v.xv;
    bus.X_PC         = v.xpc;
    bus.X_taken      = v.xt;
    bus.X_mispredict = v.xm;
    bus.X_ghr        = v.xghr;
    e.pred = v.exp_pred;
    e.ghr  = v.exp_ghr;
    e.tag  = tag;
    sb.push_back(e);
    #2;
    check_output();
  endtask

  function automatic logic [9:0] midx(logic [31:0] pc, logic [7:0] g);
    return pc[11:2] ^ {2'b00, g};
  endfunction

  function automatic int msat(int c, logic t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic logic mpred(vec_t v);
    int c;
    if (v.rst || !v.fv) return 1'b0;
    c = mpht[midx(v.fpc, mghr)];
    if (FWD && v.xv && (midx(v.xpc, v.xghr) == midx(v.fpc, mghr)))
      c = msat(c, v.xt);
    return (c >= 2);
  endfunction

  function automatic void model_step(vec_t v);
    logic p;
    p = mpred(v);
    if (v.rst) begin
      for (int i = 0; i < 1024; i++) mpht[i] = 1;
      mghr = 8'h00;
    end else begin
      if (v.xv) mpht[midx(v.xpc, v.xghr)] = msat(mpht[midx(v.xpc, v.xghr)], v.xt);
      if (v.xv && v.xm)  mghr = {v.xghr[6:0], v.xt};
      else if (v.fv)     mghr = {mghr[6:0], p};
    end
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.F_valid = 0; bus.F_PC = '0; bus.X_valid = 0; bus.X_PC = '0;
    bus.X_taken = 0; bus.X_mispredict = 0; bus.X_ghr = '0;

    //                rst fv fpc     xv xpc     xt xm xghr   pred ghr
    vecs.push_back(mk(1, 1, 'h100, 1, 'h040, 1, 1, 'hFF,  0, 'h00));
    vecs.push_back(mk(1, 0, 'h000, 0, 'h000, 0, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 1, 'h100, 0, 'h000, 0, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 0, 'h000, 0, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h040, 1, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h040, 1, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 1, 'h040, 0, 'h000, 0, 0, 'h00,  1, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h200, 0, 1, 'h80,  0, 'h01));
    vecs.push_back(mk(0, 1, 'h040, 0, 'h000, 0, 0, 'h00,  1, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h040, 1, 0, 'h00,  0, 'h01));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h040, 0, 0, 'h00,  0, 'h01));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h040, 0, 0, 'h00,  0, 'h01));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h300, 0, 1, 'h00,  0, 'h01));
    vecs.push_back(mk(0, 1, 'h040, 0, 'h000, 0, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h300, 0, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h300, 1, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 1, 'h300, 0, 'h000, 0, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h300, 1, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 1, 'h300, 0, 'h000, 0, 0, 'h00,  1, 'h00));
    vecs.push_back(mk(1, 0, 'h000, 1, 'h040, 1, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h080, 1, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h080, 1, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h0C0, 1, 0, 'h01,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h0C0, 1, 0, 'h01,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h140, 1, 0, 'h06,  0, 'h00));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h140, 1, 0, 'h06,  0, 'h00));
    vecs.push_back(mk(0, 1, 'h040, 0, 'h000, 0, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 1, 'h080, 0, 'h000, 0, 0, 'h00,  1, 'h00));
    vecs.push_back(mk(0, 1, 'h0C0, 0, 'h000, 0, 0, 'h00,  1, 'h01));
    vecs.push_back(mk(0, 1, 'h100, 0, 'h000, 0, 0, 'h00,  0, 'h03));
    vecs.push_back(mk(0, 1, 'h140, 0, 'h000, 0, 0, 'h00,  1, 'h06));
    vecs.push_back(mk(0, 0, 'h000, 0, 'h000, 0, 0, 'h00,  0, 'h0D));
    vecs.push_back(mk(0, 1, 'h080, 1, 'h400, 1, 1, 'h5A,  0, 'h0D));
    vecs.push_back(mk(0, 0, 'h000, 0, 'h000, 0, 0, 'h00,  0, 'hB5));
    vecs.push_back(mk(0, 1, 'h200, 1, 'h200, 1, 0, 'hB5,  FWD, 'hB5));
    vecs.push_back(mk(0, 0, 'h000, 0, 'h000, 0, 0, 'h00,  0, FWD ? 8'h6B : 8'h6A));
    vecs.push_back(mk(0, 0, 'h000, 1, 'h400, 1, 1, 'h5A,  0, FWD ? 8'h6B : 8'h6A));
    vecs.push_back(mk(0, 1, 'h200, 0, 'h000, 0, 0, 'h00,  1, 'hB5));
    vecs.push_back(mk(1, 1, 'h200, 1, 'h200, 0, 0, 'hB5,  0, 'h00));
    vecs.push_back(mk(0, 1, 'h080, 0, 'h000, 0, 0, 'h00,  0, 'h00));
    vecs.push_back(mk(0, 1, 'h040, 0, 'h000, 0, 0, 'h00,  0, 'h00));

    foreach (vecs[i])
      apply_stimulus(vecs[i], $sformatf("row%0d", i));

    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(v, "rand_reset");
    model_step(v);
    for (int n = 0; n < 400; n++) begin
      v.rst  = ($urandom_range(0, 59) == 0);
      v.fv   = $urandom_range(0, 1);
      v.fpc  = {20'($urandom), 6'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      v.xv   = $urandom_range(0, 1);
      v.xpc  = {20'($urandom), 6'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      v.xt   = $urandom_range(0, 1);
      v.xm   = ($urandom_range(0, 3) == 0);
      v.xghr = ($urandom_range(0, 1) == 0) ? mghr : 8'($urandom);
      v.exp_pred = mpred(v);
      v.exp_ghr  = v.rst ? 8'h00 : mghr;
      apply_stimulus(v, $sformatf("rand%0d", n));
      model_step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
